// File: rtl/alu_serial_nbit_if.sv
// Operand/result handshake bundle for alu_serial_nbit.
// The abort signal exists only when ALU_ABORT_EN is defined.
interface alu_serial_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ALUcontrol;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;
  logic             busy;
`ifdef ALU_ABORT_EN
  logic             abort;

  modport master (
    output in_valid, a, b, ALUcontrol, out_ready, abort,
    input  in_ready, out_valid, result, Z, N, C, V, busy
  );
  modport slave (
    input  in_valid, a, b, ALUcontrol, out_ready, abort,
    output in_ready, out_valid, result, Z, N, C, V, busy
  );
`else
  modport master (
    output in_valid, a, b, ALUcontrol, out_ready,
    input  in_ready, out_valid, result, Z, N, C, V, busy
  );
  modport slave (
    input  in_valid, a, b, ALUcontrol, out_ready,
    output in_ready, out_valid, result, Z, N, C, V, busy
  );
`endif
endinterface

// File: rtl/alu_serial_nbit.sv
// Serial N-bit ALU (ADD/SUB/AND/OR) stepping a SLICE-bit datapath LSB-first, with Z/N/C/V flags.
// Optional ALU_ABORT_EN adds an abort input that cancels an operation in progress.
module alu_serial_nbit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input logic              clk,
  input logic              reset,
  alu_serial_nbit_if.slave io
);

  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam int unsigned MSB   = WIDTH - 1;

  generate
    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("alu_serial_nbit: WIDTH must be >= 2 and a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q, be_q, acc, result_q;
  logic [1:0]       op_q;
  logic             carry;
  logic [CW-1:0]    count;
  logic             z_q, n_q, c_q, v_q;
  logic             abort_w;

  logic [SLICE-1:0] a_s, b_s, be_s, slice_val;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] acc_n;
  int unsigned      base;
  logic             last_step, arith;
  logic             z_n, n_n, c_n, v_n;
  logic             in_ready_c, out_valid_c, busy_c;

`ifdef ALU_ABORT_EN
  assign abort_w = io.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    base      = 32'(count) * SLICE;
    a_s       = a_q[base +: SLICE];
    b_s       = b_q[base +: SLICE];
    be_s      = be_q[base +: SLICE];
    sum       = {1'b0, a_s} + {1'b0, be_s} + {{SLICE{1'b0}}, carry};
    case (op_q)
      2'b10:   slice_val = a_s & b_s;
      2'b11:   slice_val = a_s | b_s;
      default: slice_val = sum[SLICE-1:0];
    endcase
    acc_n             = acc;
    acc_n[base +: SLICE] = slice_val;
    last_step = (count == LAST);
    arith     = ~op_q[1];
    z_n       = (acc_n == '0);
    n_n       = acc_n[MSB];
    c_n       = arith & sum[SLICE];
    v_n       = arith & (a_q[MSB] ~^ be_q[MSB]) & (acc_n[MSB] ^ a_q[MSB]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_c = ~reset;
        if (io.in_valid) state_n = ST_RUN;
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (abort_w)        state_n = ST_IDLE;
        else if (last_step) state_n = ST_DONE;
      end
      ST_DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (io.out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Slices build up in acc; result/flags commit only on the final step, so an
  // aborted op leaves the previously delivered result and flags untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      be_q     <= '0;
      op_q     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      acc      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            a_q   <= io.a;
            b_q   <= io.b;
            be_q  <= io.ALUcontrol[0] ? ~io.b : io.b;
            op_q  <= io.ALUcontrol;
            carry <= io.ALUcontrol[0];
            count <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          if (!abort_w) begin
            acc   <= acc_n;
            carry <= sum[SLICE];
            count <= count + 1'b1;
            if (last_step) begin
              result_q <= acc_n;
              z_q      <= z_n;
              n_q      <= n_n;
              c_q      <= c_n;
              v_q      <= v_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.busy      = busy_c;
  assign io.result    = result_q;
  assign io.Z         = z_q;
  assign io.N         = n_q;
  assign io.C         = c_q;
  assign io.V         = v_q;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Scoreboard bench for alu_serial_nbit: three lanes (SLICE 1, 4, 8) share stimulus;
// expected results come from a plain-arithmetic model, a monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_serial_nbit;

  localparam int unsigned W  = 8;
  localparam int          NL = 3;

  function automatic int unsigned lane_slice(int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
  endfunction

  function automatic int unsigned lane_steps(int g);
    return W / lane_slice(g);
  endfunction

  typedef struct packed {
    logic [W-1:0] r;
    logic         z, n, c, v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid, out_ready, abort;
  logic [W-1:0] a_d, b_d;
  logic [1:0]   op_d;
  logic         bp_mode;

  logic [NL-1:0] ov, ir, bz;
  logic [W-1:0]  res [NL];
  logic [3:0]    fl  [NL];

  alu_serial_nbit_if #(.WIDTH(W)) io [NL] ();

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign io[g].in_valid   = in_valid;
    assign io[g].a          = a_d;
    assign io[g].b          = b_d;
    assign io[g].ALUcontrol = op_d;
    assign io[g].out_ready  = out_ready;
`ifdef ALU_ABORT_EN
    assign io[g].abort      = abort;
`endif
    assign ov[g]  = io[g].out_valid;
    assign ir[g]  = io[g].in_ready;
    assign bz[g]  = io[g].busy;
    assign res[g] = io[g].result;
    assign fl[g]  = {io[g].Z, io[g].N, io[g].C, io[g].V};

    alu_serial_nbit #(.WIDTH(W), .SLICE(lane_slice(g))) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io[g])
    );
  end

  // Reference: plain integer arithmetic, signed range test for V.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic [1:0] op);
    exp_t        e;
    int unsigned ux, uy;
    int          sx, sy, sr;
    int          smax, smin;
    ux   = 32'(x);
    uy   = 32'(y);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    e    = '0;
    case (op)
      2'b00: begin
        e.r = W'(ux + uy);
        e.c = (ux + uy) >= (32'd1 << W);
        sr  = sx + sy;
        e.v = (sr > smax) || (sr < smin);
      end
      2'b01: begin
        e.r = W'(ux - uy);
        e.c = (ux >= uy);
        sr  = sx - sy;
        e.v = (sr > smax) || (sr < smin);
      end
      2'b10:   e.r = x & y;
      default: e.r = x | y;
    endcase
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  exp_t q [NL][$];
  int   total = 0;
  int   bad = 0;
  int   timeouts = 0;
  logic fin_req = 1'b0;
  logic fin_ack = 1'b0;

  function automatic void chk(string name, int g, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s lane%0d (slice %0d): got 0x%0h want 0x%0h at %0t",
               name, g, lane_slice(g), act, want, $time);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    int unsigned lat [NL];
    bit          armed [NL];
    bit          hs_prev [NL];
    bit          rst_prev;
    exp_t        e;
    rst_prev = 1'b0;
    for (int g = 0; g < NL; g++) begin
      lat[g] = 0; armed[g] = 1'b0; hs_prev[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NL; g++) begin
        if (reset) begin
          chk("reset_out_valid", g, 32'(ov[g]), 32'd0);
          chk("reset_in_ready", g, 32'(ir[g]), 32'd0);
          chk("reset_busy", g, 32'(bz[g]), 32'd0);
          chk("reset_result", g, 32'(res[g]), 32'd0);
          chk("reset_flags", g, 32'(fl[g]), 32'd0);
          q[g].delete();
          armed[g]   = 1'b0;
          hs_prev[g] = 1'b0;
        end else begin
          if (rst_prev)   chk("in_ready_after_reset", g, 32'(ir[g]), 32'd1);
          if (hs_prev[g]) chk("in_ready_after_handshake", g, 32'(ir[g]), 32'd1);
          hs_prev[g] = 1'b0;
          if (armed[g]) begin
            lat[g]++;
            if (ov[g]) begin
              chk("latency", g, 32'(lat[g]), 32'(lane_steps(g) + 1));
              armed[g] = 1'b0;
            end
          end
          if (ov[g]) begin
            chk("in_ready_in_done", g, 32'(ir[g]), 32'd0);
            chk("busy_in_done", g, 32'(bz[g]), 32'd1);
            if (q[g].size() == 0) begin
              chk("unexpected_out_valid", g, 32'(ov[g]), 32'd0);
            end else begin
              e = q[g][0];
              chk("result", g, 32'(res[g]), 32'(e.r));
              chk("flags_zncv", g, 32'(fl[g]), 32'({e.z, e.n, e.c, e.v}));
              if (out_ready) begin
                void'(q[g].pop_front());
                hs_prev[g] = 1'b1;
              end
            end
          end
`ifdef ALU_ABORT_EN
          if (abort && bz[g] && !ov[g]) begin
            q[g].delete();
            armed[g] = 1'b0;
          end
`endif
          if (in_valid && ir[g]) begin
            armed[g] = 1'b1;
            lat[g]   = 0;
          end
        end
      end
      rst_prev = reset;
      if (fin_req && !fin_ack) begin
        for (int g = 0; g < NL; g++) chk("queue_drained", g, 32'(q[g].size()), 32'd0);
        chk("wait_timeouts", 0, 32'(timeouts), 32'd0);
        fin_ack = 1'b1;
      end
    end
  end

  // Consumer backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (!(&ir) && n < 200) begin
      tick();
      n++;
    end
    if (!(&ir)) timeouts++;
  endtask

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic [1:0] op);
    wait_all_ready();
    if (!(&ir)) return;
    in_valid = 1'b1;
    a_d      = x;
    b_d      = y;
    op_d     = op;
    for (int g = 0; g < NL; g++) q[g].push_back(model(x, y, op));
    tick();
    in_valid = 1'b0;
    a_d      = W'($urandom);
    b_d      = W'($urandom);
    op_d     = 2'($urandom);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    in_valid = 1'b0;
    abort    = 1'b0;
    bp_mode  = 1'b0;
    a_d      = '0;
    b_d      = '0;
    op_d     = '0;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    issue(8'h7F, 8'h01, 2'b00);
    issue(8'h05, 8'h05, 2'b01);
    issue(8'h00, 8'h01, 2'b01);
    issue(8'hF0, 8'h3C, 2'b10);
    issue(8'hF0, 8'h0F, 2'b11);
    issue(8'hFF, 8'h01, 2'b00);
    issue(8'h80, 8'h01, 2'b01);

    // hold out_ready low for at least 5 DONE cycles on the slowest lane
    wait_all_ready();
    bp_mode = 1'b1;
    issue(8'h12, 8'hC3, 2'b01);
    n = 0;
    while (!ov[0] && n < 50) begin tick(); n++; end
    if (!ov[0]) timeouts++;
    repeat (5) tick();
    bp_mode = 1'b0;

    repeat (40) issue(pick(), pick(), 2'($urandom));

    // reset while the SLICE=1 lane is at count 3
    issue(8'h3A, 8'h5C, 2'b00);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

`ifdef ALU_ABORT_EN
    issue(8'h11, 8'h22, 2'b00);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (12) tick();
`endif

    repeat (10) issue(pick(), pick(), 2'($urandom));

    bp_mode = 1'b0;
    wait_all_ready();
    repeat (3) tick();
    fin_req = 1'b1;
    n = 0;
    while (!fin_ack && n < 10) begin tick(); n++; end
    if (!fin_ack) begin
      $display("FAIL final_check: monitor did not respond");
      $fatal(1, "monitor stalled");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
